// File: rtl/trees_burst_ctrl_if.sv
// trees_burst_ctrl_if: feature stream, accelerator and prediction stream signals of trees_burst_ctrl
interface trees_burst_ctrl_if #(parameter int MAX_BURST_BITS = 6);
  logic [63:0] in_data;
  logic in_valid;
  logic in_ready;
  logic flush;
  logic load_features;
  logic [31:0] feature_addr;
  logic [63:0] features2;
  logic start;
  logic [MAX_BURST_BITS-1:0] burst_len;
  logic done;
  logic [MAX_BURST_BITS-1:0] prediction_addr;
  logic [63:0] prediction;
  logic [7:0] pred_data;
  logic pred_valid;
  logic pred_ready;
  logic pred_last;
  logic busy;
  logic err;
  modport master(
    input in_data, in_valid, flush, done, prediction, pred_ready,
    output in_ready, load_features, feature_addr, features2, start, burst_len,
    output prediction_addr, pred_data, pred_valid, pred_last, busy, err
  );
  modport slave(
    output in_data, in_valid, flush, done, prediction, pred_ready,
    input in_ready, load_features, feature_addr, features2, start, burst_len,
    input prediction_addr, pred_data, pred_valid, pred_last, busy, err
  );
endinterface

// File: rtl/trees_burst_ctrl.sv
// trees_burst_ctrl: feature-burst sequencer for trees_ping_pong; TREES_BURST_CTRL_TIMEOUT_EN adds a sticky done-wait timeout
module trees_burst_ctrl #(
  parameter int N_FEATURE = 32,
  parameter int HALF_FEATURE = N_FEATURE / 2,
  parameter int MAX_BURST = 54,
  parameter int MAX_BURST_BITS = $clog2(MAX_BURST)
`ifdef TREES_BURST_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
  input logic clk,
  input logic rst,
  trees_burst_ctrl_if.master bus
);
  localparam int PW = HALF_FEATURE > 1 ? $clog2(HALF_FEATURE) : 1;
  localparam int MB = MAX_BURST_BITS;
  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT, RADDR, RDATA, EMIT} state_t;
  state_t r_state;
  logic r_in_ready, r_load, r_start, r_pv, r_plast, r_busy, r_flush;
  logic [31:0] r_wcnt, r_faddr;
  logic [63:0] r_feat, r_buf;
  logic [PW-1:0] r_part;
  logic [MB-1:0] r_scnt, r_blen, r_idx, r_paddr;
  logic [7:0] r_pdata;
  logic w_acc, w_eos, w_bnd, w_fl, w_go, w_last;
  logic [MB-1:0] w_ns, w_ni;
  assign w_acc = bus.in_valid & r_in_ready;
  assign w_eos = w_acc & (r_part == PW'(HALF_FEATURE - 1));
  assign w_ns = r_scnt + MB'(w_eos);
  assign w_bnd = w_acc ? w_eos : (r_part == '0);
  assign w_fl = r_flush | bus.flush;
  assign w_go = (w_eos & (w_ns == MB'(MAX_BURST))) | ((r_state == FILL) & w_fl & w_bnd & (w_ns != '0));
  assign w_ni = r_idx + 1'b1;
  assign w_last = r_idx == r_blen - 1'b1;
  assign bus.in_ready = r_in_ready;
  assign bus.load_features = r_load;
  assign bus.feature_addr = r_faddr;
  assign bus.features2 = r_feat;
  assign bus.start = r_start;
  assign bus.burst_len = r_blen;
  assign bus.prediction_addr = r_paddr;
  assign bus.pred_data = r_pdata;
  assign bus.pred_valid = r_pv;
  assign bus.pred_last = r_plast;
  assign bus.busy = r_busy;
`ifdef TREES_BURST_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic r_err;
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_in_ready <= 1'b0;
      r_load <= 1'b0;
      r_start <= 1'b0;
      r_pv <= 1'b0;
      r_plast <= 1'b0;
      r_busy <= 1'b0;
      r_flush <= 1'b0;
      r_wcnt <= '0;
      r_faddr <= '0;
      r_feat <= '0;
      r_buf <= '0;
      r_part <= '0;
      r_scnt <= '0;
      r_blen <= '0;
      r_idx <= '0;
      r_paddr <= '0;
      r_pdata <= '0;
`ifdef TREES_BURST_CTRL_TIMEOUT_EN
      r_tcnt <= '0;
      r_err <= 1'b0;
`endif
    end else begin
      r_load <= w_acc;
      r_start <= 1'b0;
      r_scnt <= w_ns;
      if (w_acc) begin
        r_feat <= bus.in_data;
        r_faddr <= r_wcnt;
        r_wcnt <= r_wcnt + 1'b1;
        r_part <= w_eos ? '0 : r_part + 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_in_ready <= ~w_go;
          r_busy <= w_acc;
          if (w_acc) r_state <= w_go ? LAUNCH : FILL;
        end
        FILL: begin
          r_flush <= w_fl;
          r_in_ready <= ~w_go;
          if (w_go) r_state <= LAUNCH;
        end
        LAUNCH: begin
          r_start <= 1'b1;
          r_blen <= r_scnt;
          r_state <= WAIT;
`ifdef TREES_BURST_CTRL_TIMEOUT_EN
          r_tcnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.done) begin
            r_idx <= '0;
            r_paddr <= '0;
            r_state <= RADDR;
          end
`ifdef TREES_BURST_CTRL_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy <= 1'b0;
            r_wcnt <= '0;
            r_part <= '0;
            r_scnt <= '0;
            r_flush <= 1'b0;
            r_state <= IDLE;
          end else r_tcnt <= r_tcnt + 1'b1;
`endif
        end
        RADDR: r_state <= RDATA;
        RDATA: begin
          r_buf <= bus.prediction;
          r_pdata <= bus.prediction[{r_idx[2:0], 3'b000} +: 8];
          r_pv <= 1'b1;
          r_plast <= w_last;
          r_state <= EMIT;
        end
        EMIT: if (bus.pred_ready) begin
          r_idx <= w_ni;
          if (w_last) begin
            r_pv <= 1'b0;
            r_plast <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy <= 1'b0;
            r_wcnt <= '0;
            r_part <= '0;
            r_scnt <= '0;
            r_idx <= '0;
            r_flush <= 1'b0;
            r_state <= IDLE;
          end else if (w_ni[2:0] == 3'd0) begin
            r_pv <= 1'b0;
            r_paddr <= w_ni >> 3;
            r_state <= RADDR;
          end else begin
            r_pdata <= r_buf[{w_ni[2:0], 3'b000} +: 8];
            r_plast <= w_ni == r_blen - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/trees_burst_ctrl.md
Name: trees_burst_ctrl

Overview:
Initiator-side sequencer for the trees_ping_pong accelerator.
- Accepts a stream of packed 64-bit feature words (two fp32 features per word, high feature in [63:32]).
- Writes them into the accelerator feature memory and issues start with the burst length.
- Waits for done, then reads the packed 8x8-bit prediction words and emits one 8-bit class prediction per sample as a stream.
- Sits between the host/DMA feature stream and trees_ping_pong. Tree loading stays outside this block.

Parameters:
N_FEATURE, 32, fp32 features per sample; must be even.
HALF_FEATURE, N_FEATURE/2, 64-bit feature words per sample.
MAX_BURST, 54, maximum samples per accelerator launch; must satisfy MAX_BURST < 2**MAX_BURST_BITS.
MAX_BURST_BITS, $clog2(MAX_BURST), width of burst_len and prediction_addr.
TIMEOUT_CYCLES, 65536, done-wait limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  64  feature word {feat_odd, feat_even}
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid & in_ready
flush  in  1  launch the pending partial burst
load_features  out  1  feature write strobe to accelerator
feature_addr  out  32  feature word address within the burst
features2  out  64  feature write data
start  out  1  one-cycle launch pulse
burst_len  out  MAX_BURST_BITS  samples in the launched burst
done  in  1  accelerator completion
prediction_addr  out  MAX_BURST_BITS  prediction word index
prediction  in  64  eight packed predictions; byte j is sample 8*addr+j
pred_data  out  8  class prediction
pred_valid  out  1  pred_data valid
pred_ready  in  1  consumer ready
pred_last  out  1  final prediction of the burst
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (rst high at posedge): state IDLE. All outputs zero. Word, sample and read counters zero. Flush latch cleared. Reset mid-burst abandons the burst with no further accelerator writes.
- States: IDLE, FILL, LAUNCH, WAIT, RADDR, RDATA, EMIT.
- IDLE/FILL:
  - in_ready = 1.
  - Each accepted word is registered: next cycle load_features=1, features2=in_data, feature_addr=word count. Word count increments.
  - The first accepted word moves the state to FILL.
  - Sample count increments when the word index within the sample reaches HALF_FEATURE-1.
- Flush:
  - Sampled every cycle in FILL and latched.
  - Acted on only at a sample boundary (zero partial words).
  - Flush in IDLE with no samples is ignored.
  - Flush arriving mid-sample waits until that sample completes.
- FILL -> LAUNCH when sample count == MAX_BURST, or when the flush latch is set at a sample boundary. in_ready drops in the same cycle as the transition decision. The final feature write still issues the cycle after.
- LAUNCH: one cycle after the final load_features. start=1 for exactly one cycle. burst_len = sample count, held stable until the next LAUNCH. -> WAIT.
- WAIT: stay until done=1; done is treated as level. -> RADDR with read index 0.
- RADDR: drive prediction_addr = index/8. -> RDATA.
- RDATA: prediction is valid this cycle (one-cycle registered read latency). Capture it into an internal 64-bit buffer. -> EMIT.
- EMIT:
  - pred_data = buffer byte (index mod 8). pred_valid=1.
  - pred_data is held stable while pred_valid & !pred_ready.
  - On handshake the index increments.
  - If index == burst_len-1: pred_last=1 with that beat; after the handshake, clear counters and flush latch -> IDLE.
  - Else if the new index mod 8 == 0 -> RADDR.
- Partial last word: only burst_len mod 8 bytes are emitted; the remaining bytes are discarded.
- Burst lengths 1..MAX_BURST are legal. burst_len=0 never issues.
- start is never asserted while load_features is high. in_ready is 0 in LAUNCH through EMIT.
- Input words accepted during FILL are never dropped or reordered. Predictions are emitted in sample order.

Optional Feature:
Macro TREES_BURST_CTRL_TIMEOUT_EN.
- Defined: a WAIT-state cycle counter. If done has not been seen after TIMEOUT_CYCLES cycles, set err (sticky until rst), discard the burst (no predictions emitted), clear counters -> IDLE.
- Undefined: no counter; WAIT waits forever; err is tied to 0.

Test Plan:
- Full burst: stream 54*16=864 words with in_valid held high -> 864 load_features pulses at addr 0..863, then a start pulse with burst_len=54. Model done 200 cycles later -> 54 predictions in order, pred_last on the 54th, 7 prediction_addr reads (0..6).
- Flush partial: 3 samples (48 words) then flush -> start with burst_len=3. Prediction word 0x0000000000050201 -> pred_data 1,2,5; pred_last on 5.
- Flush mid-sample: flush pulsed after word 20 (sample 1 incomplete) -> no start until word 32 is accepted; then burst_len=2.
- Backpressure: pred_ready toggles 1/0 each cycle during a burst_len=9 readout -> 9 beats, pred_data stable while stalled, prediction_addr reads 0 and 1 only once each.
- Reset mid-WAIT: rst asserted for 1 cycle -> busy=0, in_ready=1 next cycle, no pred_valid. A new 1-sample burst completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=100): done never asserted -> err=1 after 100 WAIT cycles, returns to IDLE, no pred_valid; err stays 1 until rst.
